// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control slice.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        MULDIV = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MULDIV_LAT_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc cycles, holds at all-ones, synchronous clear.
// Update visible one cycle after the event.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: start-up gating, load-use bubbles, branch flush, mult/div hold.
// Control outputs are combinational from state and inputs; stall/flush counters lag one cycle.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             ID_muldiv_i,
    input  logic             Branch_taken_i,
    output logic             PCwr_o,
    output logic             IFIDwr_o,
    output logic             nope_o,
    output logic             Flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // The issuing cycle counts toward occupancy, so MULDIV runs LAT-1 cycles.
    localparam logic [3:0] MD_LOAD = (MULDIV_LAT > 1) ? 4'(MULDIV_LAT - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       hz;
    logic       stall_inc;

    assign hz = IDEX_MemRead_i && (IDEX_Rt_i != REG_ZERO) &&
                ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        PCwr_o    = 1'b0;
        IFIDwr_o  = 1'b0;
        nope_o    = 1'b1;
        Flush_o   = 1'b0;
        busy_o    = 1'b0;
        stall_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (!start) state_d = IDLE;
                if (hz) begin
                    stall_inc = 1'b1;
                end else begin
                    PCwr_o   = 1'b1;
                    IFIDwr_o = 1'b1;
                    nope_o   = 1'b0;
                    Flush_o  = Branch_taken_i;
                    // A mult/div already issued into EX must finish even if start drops.
                    if (ID_muldiv_i && (MULDIV_LAT > 1)) begin
                        rem_d   = MD_LOAD;
                        state_d = MULDIV;
                    end
                end
            end
            MULDIV: begin
                busy_o    = 1'b1;
                stall_inc = 1'b1;
                if (rem_q == 4'd0) begin
                    state_d = start ? RUN : IDLE;
                end else begin
                    rem_d = rem_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Flush_o),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MULDIV_LAT=4, CNT_W=4).
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       IDEX_MemRead_i;
    logic [4:0] IDEX_Rt_i;
    logic [4:0] IFID_Rs_i;
    logic [4:0] IFID_Rt_i;
    logic       ID_muldiv_i;
    logic       Branch_taken_i;
    logic       PCwr_o, IFIDwr_o, nope_o, Flush_o, busy_o;
    logic [3:0] stall_cnt_o, flush_cnt_o;

    int tests  = 0;
    int failed = 0;

    // Control vector order: {PCwr, IFIDwr, nope, Flush, busy}
    localparam logic [4:0] C_IDLE  = 5'b00100;
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00100;
    localparam logic [4:0] C_FLUSH = 5'b11010;
    localparam logic [4:0] C_BUSY  = 5'b00101;

    pipeline_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_Rt_i      (IDEX_Rt_i),
        .IFID_Rs_i      (IFID_Rs_i),
        .IFID_Rt_i      (IFID_Rt_i),
        .ID_muldiv_i    (ID_muldiv_i),
        .Branch_taken_i (Branch_taken_i),
        .PCwr_o         (PCwr_o),
        .IFIDwr_o       (IFIDwr_o),
        .nope_o         (nope_o),
        .Flush_o        (Flush_o),
        .busy_o         (busy_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        #1;
        obs = {PCwr_o, IFIDwr_o, nope_o, Flush_o, busy_o};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: count observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_hz();
        IDEX_MemRead_i = 1'b0;
        IDEX_Rt_i      = 5'd0;
        IFID_Rs_i      = 5'd0;
        IFID_Rt_i      = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ID_muldiv_i = 1'b0;
        Branch_taken_i = 1'b0;
        clear_hz();

        // Reset and start-up
        tick();
        tick();
        chk_ctl("reset_ctl", C_IDLE);
        chk_cnt("reset_stall", stall_cnt_o, 4'd0);
        chk_cnt("reset_flush", flush_cnt_o, 4'd0);
        rst = 1'b0;
        tick();
        chk_ctl("idle_no_start", C_IDLE);
        start = 1'b1;
        chk_ctl("idle_start_same_cycle", C_IDLE);
        tick();
        chk_ctl("run_after_start", C_RUN);

        // Load-use on rs
        IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd8; IFID_Rs_i = 5'd8;
        chk_ctl("loaduse_rs", C_STALL);
        chk_cnt("loaduse_cnt_lag", stall_cnt_o, 4'd0);
        tick();
        clear_hz();
        chk_ctl("loaduse_released", C_RUN);
        chk_cnt("loaduse_cnt", stall_cnt_o, 4'd1);

        // Load of $zero never stalls
        IDEX_MemRead_i = 1'b1;
        chk_ctl("load_r0_nostall", C_RUN);
        tick();
        chk_cnt("load_r0_cnt", stall_cnt_o, 4'd1);

        // Load-use on rt
        IDEX_Rt_i = 5'd5; IFID_Rt_i = 5'd5; IFID_Rs_i = 5'd3;
        chk_ctl("loaduse_rt", C_STALL);
        tick();
        clear_hz();
        chk_cnt("loaduse_rt_cnt", stall_cnt_o, 4'd2);

        // Non-load with matching register: no stall
        IDEX_Rt_i = 5'd7; IFID_Rs_i = 5'd7;
        chk_ctl("nonload_match", C_RUN);
        clear_hz();

        // Branch alone
        Branch_taken_i = 1'b1;
        chk_ctl("branch_flush", C_FLUSH);
        tick();
        Branch_taken_i = 1'b0;
        chk_cnt("branch_flush_cnt", flush_cnt_o, 4'd1);

        // Branch with hazard: stall wins
        IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd9; IFID_Rs_i = 5'd9; Branch_taken_i = 1'b1;
        chk_ctl("branch_hz", C_STALL);
        tick();
        clear_hz(); Branch_taken_i = 1'b0;
        chk_cnt("branch_hz_flush", flush_cnt_o, 4'd1);
        chk_cnt("branch_hz_stall", stall_cnt_o, 4'd3);

        // Mult/div with branch held through the busy window
        ID_muldiv_i = 1'b1;
        chk_ctl("muldiv_issue", C_RUN);
        tick();
        ID_muldiv_i = 1'b0; Branch_taken_i = 1'b1;
        chk_ctl("muldiv_busy1", C_BUSY);
        chk_cnt("muldiv_cnt0", stall_cnt_o, 4'd3);
        tick();
        chk_ctl("muldiv_busy2", C_BUSY);
        chk_cnt("muldiv_cnt1", stall_cnt_o, 4'd4);
        tick();
        chk_ctl("muldiv_busy3", C_BUSY);
        chk_cnt("muldiv_cnt2", stall_cnt_o, 4'd5);
        tick();
        chk_ctl("muldiv_back_flush", C_FLUSH);
        chk_cnt("muldiv_cnt3", stall_cnt_o, 4'd6);
        chk_cnt("muldiv_no_early_flush", flush_cnt_o, 4'd1);
        tick();
        Branch_taken_i = 1'b0;
        chk_cnt("muldiv_flush_after", flush_cnt_o, 4'd2);

        // Start dropped in first MULDIV cycle
        ID_muldiv_i = 1'b1;
        tick();
        ID_muldiv_i = 1'b0; start = 1'b0;
        chk_ctl("drop_busy1", C_BUSY);
        tick();
        chk_ctl("drop_busy2", C_BUSY);
        tick();
        chk_ctl("drop_busy3", C_BUSY);
        tick();
        chk_ctl("drop_idle", C_IDLE);
        chk_cnt("drop_stall_cnt", stall_cnt_o, 4'd9);
        start = 1'b1;
        tick();
        chk_ctl("drop_restart", C_RUN);

        // Reset in second MULDIV cycle
        ID_muldiv_i = 1'b1;
        tick();
        ID_muldiv_i = 1'b0;
        tick();
        chk_ctl("rst_mid_busy2", C_BUSY);
        rst = 1'b1;
        tick();
        chk_ctl("rst_mid_idle", C_IDLE);
        chk_cnt("rst_mid_stall", stall_cnt_o, 4'd0);
        chk_cnt("rst_mid_flush", flush_cnt_o, 4'd0);
        rst = 1'b0;
        tick();
        chk_ctl("rst_mid_run", C_RUN);

        // Saturation: 20 consecutive load-use stalls
        IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd8; IFID_Rs_i = 5'd8;
        for (int i = 0; i < 14; i++) tick();
        chk_cnt("sat_14", stall_cnt_o, 4'd14);
        for (int i = 0; i < 6; i++) tick();
        chk_cnt("sat_20", stall_cnt_o, 4'd15);
        tick();
        tick();
        chk_cnt("sat_hold", stall_cnt_o, 4'd15);
        chk_ctl("sat_still_stall", C_STALL);
        clear_hz();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
